// File: rtl/fifo8_pkg.sv
// Shared constants and types for the 8-entry FIFO.
// Defining FIFO8_BYPASS_EN in fifo8.sv adds a same-cycle path from enq to deq when empty.
package fifo8_pkg;

   localparam int unsigned FIFO8_DEPTH = 8;
   localparam int unsigned FIFO8_PTR_W = 3;
   localparam int unsigned FIFO8_CNT_W = 4;

   typedef logic [FIFO8_PTR_W-1:0] ptr_t;
   typedef logic [FIFO8_CNT_W-1:0] cnt_t;

endpackage

// File: rtl/fifo8_mux8.sv
// Eight-way word selector used to read the FIFO head entry.
// Entry k occupies bits [k*WIDTH +: WIDTH] of the flattened input.
module fifo8_mux8
   import fifo8_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [FIFO8_DEPTH*WIDTH-1:0] in_flat,
   input  logic [FIFO8_PTR_W-1:0]       sel,
   output logic [WIDTH-1:0]             out
);

   assign out = in_flat[sel*WIDTH +: WIDTH];

endmodule

// File: rtl/fifo8.sv
// 8-entry synchronous FIFO with valid/ready handshakes, flush and async reset.
// Optional FIFO8_BYPASS_EN: an empty FIFO forwards enq_data to deq_data combinationally.
module fifo8
   import fifo8_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             enq_valid,
   output logic             enq_ready,
   input  logic [WIDTH-1:0] enq_data,
   output logic             deq_valid,
   input  logic             deq_ready,
   output logic [WIDTH-1:0] deq_data,
   output logic [3:0]       count
);

   logic [WIDTH-1:0] mem_q [FIFO8_DEPTH];
   logic [FIFO8_DEPTH*WIDTH-1:0] mem_flat;
   logic [WIDTH-1:0] head_data;

   ptr_t head_q, head_d;
   ptr_t tail_q, tail_d;
   cnt_t cnt_q, cnt_d;

   logic empty, full;
   logic enq_fire, deq_fire;

   assign empty = (cnt_q == cnt_t'(0));
   assign full  = (cnt_q == cnt_t'(FIFO8_DEPTH));

   assign enq_ready = ~full;
   assign count     = cnt_q;

   for (genvar i = 0; i < FIFO8_DEPTH; i++) begin : g_flat
      assign mem_flat[i*WIDTH +: WIDTH] = mem_q[i];
   end

   fifo8_mux8 #(
      .WIDTH (WIDTH)
   ) u_head_mux (
      .in_flat (mem_flat),
      .sel     (head_q),
      .out     (head_data)
   );

`ifdef FIFO8_BYPASS_EN
   logic bypass;

   // Bypass only while empty; a passed-through entry never touches storage.
   assign bypass    = empty & enq_valid & ~flush;
   assign deq_valid = ~empty | bypass;
   assign deq_data  = bypass ? enq_data : head_data;
   assign enq_fire  = enq_valid & enq_ready & ~(bypass & deq_ready);
   assign deq_fire  = deq_valid & deq_ready & ~bypass;
`else
   assign deq_valid = ~empty;
   assign deq_data  = head_data;
   assign enq_fire  = enq_valid & enq_ready;
   assign deq_fire  = deq_valid & deq_ready;
`endif

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      if (flush) begin
         head_d = '0;
         tail_d = '0;
         cnt_d  = '0;
      end else begin
         if (enq_fire) tail_d = tail_q + ptr_t'(1);
         if (deq_fire) head_d = head_q + ptr_t'(1);
         unique case ({enq_fire, deq_fire})
            2'b10:   cnt_d = cnt_q + cnt_t'(1);
            2'b01:   cnt_d = cnt_q - cnt_t'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (enq_fire && !flush) mem_q[tail_q] <= enq_data;
   end

endmodule

// File: tb/tb_fifo8.sv
// Directed self-checking bench for fifo8 (WIDTH=32).
// Define FIFO8_BYPASS_EN for both files to exercise the bypass expectations.
module tb_fifo8;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        enq_valid;
   logic        enq_ready;
   logic [31:0] enq_data;
   logic        deq_valid;
   logic        deq_ready;
   logic [31:0] deq_data;
   logic [3:0]  count;

   int n_total = 0;
   int n_pass  = 0;

   fifo8 #(
      .WIDTH (32)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .enq_valid (enq_valid),
      .enq_ready (enq_ready),
      .enq_data  (enq_data),
      .deq_valid (deq_valid),
      .deq_ready (deq_ready),
      .deq_data  (deq_data),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Advance past the next rising edge; inputs change and outputs settle 1 time unit later.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] d);
      enq_valid = 1'b1;
      enq_data  = d;
      tick();
      enq_valid = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      enq_valid = 1'b0;
      enq_data  = '0;
      deq_ready = 1'b0;
      #2;
      check("rst_count", 32'(count), 32'd0);
      check("rst_deq_valid", 32'(deq_valid), 32'd0);
      check("rst_enq_ready", 32'(enq_ready), 32'd1);
      #6 rst = 1'b0;
      tick();

      // Three entries in, then drained in order
      push(32'h11);
      push(32'h22);
      push(32'h33);
      check("s1_count3", 32'(count), 32'd3);
      check("s1_head", deq_data, 32'h11);
      check("s1_valid", 32'(deq_valid), 32'd1);
      deq_ready = 1'b1;
      check("s1_out0", deq_data, 32'h11);
      tick();
      check("s1_out1", deq_data, 32'h22);
      tick();
      check("s1_out2", deq_data, 32'h33);
      tick();
      deq_ready = 1'b0;
      check("s1_count0", 32'(count), 32'd0);
      check("s1_empty", 32'(deq_valid), 32'd0);

      // Fill to 8, then an offer while full with a dequeue
      for (int i = 0; i < 8; i++) push(32'hA0 + 32'(i));
      check("s2_count8", 32'(count), 32'd8);
      check("s2_full_ready", 32'(enq_ready), 32'd0);
      enq_valid = 1'b1;
      enq_data  = 32'hFF;
      deq_ready = 1'b1;
      #1;
      check("s2_head_a0", deq_data, 32'hA0);
      tick();
      enq_valid = 1'b0;
      check("s2_count7", 32'(count), 32'd7);
      check("s2_ready_again", 32'(enq_ready), 32'd1);
      for (int i = 1; i < 8; i++) begin
         check("s2_drain", deq_data, 32'hA0 + 32'(i));
         tick();
      end
      deq_ready = 1'b0;
      check("s2_count0", 32'(count), 32'd0);
      check("s2_empty", 32'(deq_valid), 32'd0);

      // Steady state at occupancy 3 over 20 cycles
      push(32'h100);
      push(32'h101);
      push(32'h102);
      enq_valid = 1'b1;
      deq_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         enq_data = 32'h103 + 32'(i);
         #1;
         check("s3_order", deq_data, 32'h100 + 32'(i));
         tick();
         check("s3_count3", 32'(count), 32'd3);
      end
      enq_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("s3_tail", deq_data, 32'h114 + 32'(i));
         tick();
      end
      deq_ready = 1'b0;
      check("s3_count0", 32'(count), 32'd0);

      // Flush with a concurrent enqueue
      for (int i = 0; i < 5; i++) push(32'h40 + 32'(i));
      check("s4_count5", 32'(count), 32'd5);
      flush     = 1'b1;
      enq_valid = 1'b1;
      enq_data  = 32'h55;
      tick();
      flush     = 1'b0;
      enq_valid = 1'b0;
      check("s4_count0", 32'(count), 32'd0);
      check("s4_valid0", 32'(deq_valid), 32'd0);
      push(32'h66);
      push(32'h67);
      check("s4_count2", 32'(count), 32'd2);
      deq_ready = 1'b1;
      check("s4_first", deq_data, 32'h66);
      tick();
      check("s4_second", deq_data, 32'h67);
      tick();
      deq_ready = 1'b0;
      check("s4_drained", 32'(count), 32'd0);

      // Asynchronous reset mid-cycle at occupancy 6
      for (int i = 0; i < 6; i++) push(32'hC0 + 32'(i));
      check("s5_count6", 32'(count), 32'd6);
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check("s5_count0", 32'(count), 32'd0);
      check("s5_valid0", 32'(deq_valid), 32'd0);
      check("s5_ready1", 32'(enq_ready), 32'd1);
      #1 rst = 1'b0;
      tick();
      check("s5_still0", 32'(count), 32'd0);

      // Empty FIFO, enqueue with consumer ready
      enq_valid = 1'b1;
      enq_data  = 32'h77;
      deq_ready = 1'b1;
      #1;
`ifdef FIFO8_BYPASS_EN
      check("s6_byp_valid", 32'(deq_valid), 32'd1);
      check("s6_byp_data", deq_data, 32'h77);
      tick();
      enq_valid = 1'b0;
      check("s6_byp_count", 32'(count), 32'd0);
      check("s6_byp_empty", 32'(deq_valid), 32'd0);
`else
      check("s6_nobyp_valid", 32'(deq_valid), 32'd0);
      tick();
      enq_valid = 1'b0;
      check("s6_late_valid", 32'(deq_valid), 32'd1);
      check("s6_late_data", deq_data, 32'h77);
      check("s6_late_count", 32'(count), 32'd1);
      tick();
      check("s6_drained", 32'(count), 32'd0);
`endif
      deq_ready = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/fifo8.md
FIFO8 -- requirements
Module: fifo8

Interface
REQ-001 Parameter WIDTH, default 32, sets the bit width of every stored entry.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port flush, input, 1 bit: synchronous discard of all contents.
REQ-005 Port enq_valid, input, 1 bit: producer offers enq_data this cycle.
REQ-006 Port enq_ready, output, 1 bit: the FIFO can accept an entry this cycle.
REQ-007 Port enq_data, input, WIDTH bits: the entry being offered.
REQ-008 Port deq_valid, output, 1 bit: deq_data holds the oldest entry.
REQ-009 Port deq_ready, input, 1 bit: the consumer takes deq_data this cycle.
REQ-010 Port deq_data, output, WIDTH bits: the head entry.
REQ-011 Port count, output, 4 bits: current occupancy, 0..8.

Function
REQ-012 Storage SHALL be 8 entries of WIDTH bits, addressed by a 3-bit head pointer and a 3-bit tail pointer that wrap from 7 to 0.
REQ-013 An enqueue SHALL occur when enq_valid and enq_ready are both high; it writes enq_data at tail and advances tail by 1.
REQ-014 A dequeue SHALL occur when deq_valid and deq_ready are both high; it advances head by 1.
REQ-015 enq_ready SHALL equal (count != 8); it is combinational from state only and never depends on deq_ready.
REQ-016 deq_valid SHALL equal (count != 0), except as extended by REQ-025.
REQ-017 deq_data SHALL equal storage[head], selected combinationally; its value is don't-care while deq_valid is low.
REQ-018 count SHALL update each cycle as follows:
- +1 on enqueue only.
- -1 on dequeue only.
- Unchanged on both or neither.
REQ-019 Latency from an accepted enqueue into an empty FIFO to deq_valid high SHALL be 1 cycle when FIFO8_BYPASS_EN is undefined.
REQ-020 Simultaneous enqueue and dequeue at count 1..7 SHALL leave count unchanged and move both pointers.
REQ-021 When full, no enqueue SHALL occur even if a dequeue happens in the same cycle.
REQ-022 Flush SHALL take priority over enqueue and dequeue. At the next edge, head, tail and count go to 0, and any same-cycle enqueue is dropped.
REQ-023 FIFO order SHALL be strict: entries leave in exactly the order they were accepted, across pointer wrap-around.

Reset
REQ-024 Asserting rst SHALL immediately force head=0, tail=0 and count=0, giving deq_valid=0 and enq_ready=1. Storage contents are not reset. Reset mid-operation discards all entries.

Configuration
REQ-025 With macro FIFO8_BYPASS_EN defined, an empty FIFO presenting enq_valid high SHALL behave as follows:
- deq_valid=1 and deq_data=enq_data in the same cycle.
- If deq_ready is also high, the entry passes through: it is not written, and the pointers and count are unchanged.
- If deq_ready is low, the entry is enqueued normally.
- Flush suppresses the bypass: deq_valid stays at the REQ-016 value.
REQ-026 With FIFO8_BYPASS_EN undefined, no combinational path SHALL exist from enq_* to deq_*.

Structure
REQ-027 Constants FIFO8_DEPTH=8, FIFO8_PTR_W=3 and FIFO8_CNT_W=4 SHALL live in the shared core package.
REQ-028 The head-entry read SHALL be a single mux8 sub-module instance per data word: the 8 entries feed it and head drives its select. No other sub-module is used.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Reset, then enqueue 0x11, 0x22, 0x33 with deq_ready=0 -> count=3, deq_data=0x11. Then deq_ready=1 for 3 cycles -> outputs 0x11, 0x22, 0x33, and count returns to 0.
- Enqueue 8 entries 0xA0..0xA7 -> count=8, enq_ready=0. A 9th offer of 0xFF while full with deq_ready=1 -> 0xA0 leaves, 0xFF is not accepted, count=7.
- Steady state, 20 cycles of enq_valid=1 and deq_ready=1 with incrementing data starting at occupancy 3 -> count stays 3, output is in order, and pointers wrap twice.
- Enqueue 5 entries, then flush with enq_valid=1 and data 0x55 -> next cycle count=0, deq_valid=0, and 0x55 is never output.
- Assert rst asynchronously mid-cycle at count=6 -> deq_valid falls and count=0 before the next clk edge, and enq_ready=1.
- With FIFO8_BYPASS_EN defined: empty FIFO, enq 0x77 with deq_ready=1 -> deq_valid=1 and deq_data=0x77 in the same cycle, count stays 0. Without the macro, deq_valid=0 that cycle and 0x77 appears one cycle later.
